// File: rtl/rom_arbiter.sv
// Purpose: shares one synchronous image ROM read port among N_REQ draw stages, with a tagged return path.
// Latency: gnt/rom_addr are registered one pclk after req; rvalid/rdata follow ROM_LAT pclk after gnt.
// Backpressure: req/gnt only; a just-granted requester is masked for one edge, and returns are never stalled.
// Build option ROM_ARB_FIXED_PRIO_EN: lowest eligible index wins and the round-robin pointer is dropped.
module rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  elig;
  logic              lo_vld;
  logic [IDX_W-1:0]  lo_idx;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [ADDR_W-1:0] win_addr;
  logic [N_REQ-1:0]  ret_oh;

  // Tag pipe: one {valid, index} entry per cycle of ROM latency.
  logic              tag_vld [ROM_LAT];
  logic [IDX_W-1:0]  tag_idx [ROM_LAT];

  // A requester granted this cycle sits out the next edge so a held req is not served twice.
  assign elig = req & ~gnt;

  // Lowest eligible index overall; this is the fixed-priority winner and the round-robin wrap-around case.
  always_comb begin
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_vld = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
  end

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest eligible index always wins.
  always_comb begin
    win_vld = lo_vld;
    win_idx = lo_idx;
  end
`else
  logic             hi_vld;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] ptr;

  // Round robin: lowest eligible index at or above ptr, otherwise wrap to the lowest eligible overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (IDX_W'(i) >= ptr)) begin
        hi_vld = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
    win_vld = hi_vld | lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

  // The pointer moves just past the winner so it has the lowest priority next time.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (win_vld) begin
      if (win_idx == IDX_W'(N_REQ - 1)) ptr <= '0;
      else                              ptr <= win_idx + 1'b1;
    end
  end
`endif

  // Winner one-hot, the winner's address, and the one-hot owner of the returning data.
  always_comb begin
    win_oh   = '0;
    ret_oh   = '0;
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_oh[i] = 1'b1;
        win_addr  = addr_in[i*ADDR_W +: ADDR_W];
      end
      if (IDX_W'(i) == tag_idx[ROM_LAT-1]) ret_oh[i] = 1'b1;
    end
  end

  // Grant pulse and ROM address; the address holds when nobody wins.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      rom_addr <= '0;
    end else begin
      gnt <= win_vld ? win_oh : '0;
      if (win_vld) rom_addr <= win_addr;
    end
  end

  // Tag shift register tracking which requester owns each read in flight.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= win_vld;
      tag_idx[0] <= win_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Return stage: capture ROM data for the tagged owner; rdata holds between returns.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else if (tag_vld[ROM_LAT-1]) begin
      rdata  <= rom_data;
      rvalid <= ret_oh;
    end else begin
      rvalid <= '0;
    end
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous image ROM read port among up to `N_REQ` draw stages in the VGA pipeline (background, cars, HUD, cursor). Each stage issues a pixel address with a req/gnt handshake. The arbiter drives the ROM address and routes returning pixel data back to the winning stage with a tagged, fixed-latency return path. It sits between the draw stages and the image ROM, in the `pclk` domain.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 12, ROM address width
- `DATA_W`, 12, ROM data width (rgb 4:4:4)
- `ROM_LAT`, 1, ROM read latency in `pclk` cycles from `rom_addr` change to valid `rom_data` (1..3)

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester read request, level.
- `addr_in` in N_REQ*ADDR_W: packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `gnt` out N_REQ: one-hot grant, registered, one-cycle pulse.
- `rom_addr` out ADDR_W: registered address to ROM.
- `rom_data` in DATA_W: ROM read data.
- `rdata` out DATA_W: registered returned data, shared by all requesters.
- `rvalid` out N_REQ: one-hot, marks which requester owns `rdata` this cycle.

## Operation
- **Arbitration.** At each `pclk` edge the eligible set is `req & ~gnt`. A requester granted in the current cycle is masked out for one edge, which prevents double service of a held request.
- **Empty eligible set.** `gnt` goes to 0. `rom_addr` holds its value. No tag is issued.
- **Non-empty eligible set.** The winner is the first eligible index at or after `ptr`, searching cyclically. Three registers update on that edge:
  - `gnt` is set to onehot(winner).
  - `rom_addr` is set to `addr_in[winner]`.
  - `ptr` is set to (winner+1) mod N_REQ.
- **Handshake rules.**
  - A requester holds `req` and `addr_in` stable until it sees `gnt[i]`=1.
  - The address is captured on the same edge that raises `gnt[i]`.
  - The requester may change `addr_in`, or drop `req`, in the cycle `gnt[i]` is high.
  - Dropping `req` before a grant is legal and drops the request silently.
- **Tag pipe.** The pipe is a shift register of depth `ROM_LAT`, each entry holding {valid, index}.
  - Entry 0 is loaded with {1, winner} on a grant edge and {0, x} otherwise.
  - When the last entry is valid, on the next edge `rdata` is set to `rom_data` and `rvalid` is set to onehot(index). Otherwise `rvalid` is set to 0 and `rdata` holds its value.
- **Throughput.**
  - One grant per cycle, with no bubbles when two or more requesters are active.
  - A single requester holding `req` continuously is served every second cycle, because of the mask.
- **Reset (`rst_n`=0), any time.**
  - `gnt`=0, `rvalid`=0, `rom_addr`=0, `rdata`=0, `ptr`=0, all tags cleared.
  - In-flight reads are discarded and never return.
  - The first edge after release arbitrates normally.

## Timing
- Grant latency: `req` asserted before edge k, on an idle arbiter with the winner at `ptr`. Then `gnt` and `rom_addr` are valid in cycle k+1.
- Data latency: `rvalid[i]`/`rdata` are valid in cycle k+1+`ROM_LAT`, i.e. `ROM_LAT` cycles after `gnt[i]`.
- The return order equals the grant order. At most one `rvalid` bit is ever high.
- No combinational path exists from any input to any output.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority, with the lowest eligible index winning. `ptr` is removed. The grant mask still applies.
  - **Undefined (default):** round-robin as described above.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-stream with 2 tags in flight (`ROM_LAT`=2) -> all outputs 0 immediately; release -> no stale `rvalid` ever appears.
- **Single read:** `req`=0001, `addr_in[0]`=12'h0A5, ROM model returns addr^12'hFFF -> `gnt`=0001 in cycle k+1, `rom_addr`=0A5; `rvalid`=0001 with `rdata`=F5A in cycle k+1+`ROM_LAT`.
- **Round-robin:** `req`=1111 held, each with a distinct address -> grants 0001, 0010, 0100, 1000, 0001... on consecutive cycles, with no idle cycle; rvalid sequence matches the grants, delayed by `ROM_LAT`.
- **Single hog:** `req`=0100 held constantly -> `gnt` alternates 0100/0000. Then add `req[1]` -> grants 0100, 0010, 0100, 0010.
- **Withdrawal:** `req[3]` raised then dropped before a grant while `req[0]` is busy -> `req[3]` is never granted and never returns data.
- **Fixed priority (macro defined):** `req`=1010 held -> grants 0010, 1000, 0010, 1000 (mask-driven). `req`=1011 -> 0001, 0010, 0001, 0010; `req[3]` is starved.
